// File: rtl/tis_fetch_unit_if.sv
// Decoder / instruction-memory bundle for the TIS-100 fetch unit.
// master: decoder + control side drives jump info, ACC, length, stall,
//   hlt, ackw and observes pc_o, fetch_valid_o, halted_o,
//   jump_taken_o, wrap_o.
// slave: the fetch unit itself.
interface tis_fetch_unit_if #(
    parameter int AW = 8,
    parameter int DW = 11
);
    logic [2:0]    jmp_kind;
    logic [AW-1:0] jmp_target;
    logic [DW-1:0] jro_off;
    logic [DW-1:0] acc;
    logic [AW:0]   prog_len;
    logic          stall;
    logic          hlt;
    logic          ackw;

    logic [AW-1:0] pc_o;
    logic          fetch_valid_o;
    logic          halted_o;
    logic          jump_taken_o;
    logic          wrap_o;

    modport master (
        output jmp_kind,
        output jmp_target,
        output jro_off,
        output acc,
        output prog_len,
        output stall,
        output hlt,
        output ackw,
        input  pc_o,
        input  fetch_valid_o,
        input  halted_o,
        input  jump_taken_o,
        input  wrap_o
    );

    modport slave (
        input  jmp_kind,
        input  jmp_target,
        input  jro_off,
        input  acc,
        input  prog_len,
        input  stall,
        input  hlt,
        input  ackw,
        output pc_o,
        output fetch_valid_o,
        output halted_o,
        output jump_taken_o,
        output wrap_o
    );
endinterface

// File: rtl/tis_fetch_unit.sv
// Program counter and fetch control for a TIS-100 execution node.
// Ports: clk, reset (async, active-high), bus (slave modport) carrying
//   jump kind/target/JRO offset, ACC, program length, stall, hlt, ackw
//   in; pc_o, fetch_valid_o, halted_o, jump_taken_o, wrap_o out.
module tis_fetch_unit #(
    parameter int AW = 8,
    parameter int DW = 11
) (
    input  logic             clk,
    input  logic             reset,
    tis_fetch_unit_if.slave  bus
);
    // JRO sum width: wide enough for pc (unsigned) and offset (signed)
    localparam int SW = (((AW + 1) > DW) ? (AW + 1) : DW) + 1;

    localparam logic [2:0] K_NONE = 3'd0;
    localparam logic [2:0] K_JMP  = 3'd1;
    localparam logic [2:0] K_JEZ  = 3'd2;
    localparam logic [2:0] K_JNZ  = 3'd3;
    localparam logic [2:0] K_JGZ  = 3'd4;
    localparam logic [2:0] K_JLZ  = 3'd5;
    localparam logic [2:0] K_JRO  = 3'd6;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          jt_q, jt_d;
    logic          wrap_q, wrap_d;

    logic [AW:0]   len_eff;
    logic [AW-1:0] len_m1;
    logic [AW:0]   pc_inc;
    logic          seq_wrap;
    logic [AW-1:0] seq_pc;

    logic          acc_z;
    logic          acc_neg;
    logic          cond_taken;
    logic [AW-1:0] abs_pc;

    logic signed [SW-1:0] pc_x;
    logic signed [SW-1:0] off_x;
    logic signed [SW-1:0] len_x;
    logic signed [SW-1:0] sum_s;
    logic [AW-1:0]        jro_pc;

    logic          take;
    logic [AW-1:0] next_pc;

    // Length 0 behaves as 1 so there is always one valid slot
    assign len_eff = (bus.prog_len == '0) ? {{AW{1'b0}}, 1'b1}
                                          : bus.prog_len;
    // Low AW bits minus one is correct even when len_eff == 2^AW
    assign len_m1  = len_eff[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};

    // >= also covers a PC left beyond a shrunken program
    assign pc_inc   = {1'b0, pc_q} + {{AW{1'b0}}, 1'b1};
    assign seq_wrap = (pc_inc >= len_eff);
    assign seq_pc   = seq_wrap ? '0 : pc_inc[AW-1:0];

    assign acc_z   = (bus.acc == '0);
    assign acc_neg = bus.acc[DW-1];

    always_comb begin
        cond_taken = 1'b0;
        case (bus.jmp_kind)
            K_JMP:   cond_taken = 1'b1;
            K_JEZ:   cond_taken = acc_z;
            K_JNZ:   cond_taken = !acc_z;
            K_JGZ:   cond_taken = !acc_z && !acc_neg;
            K_JLZ:   cond_taken = acc_neg;
            default: cond_taken = 1'b0;
        endcase
    end

    assign abs_pc = ({1'b0, bus.jmp_target} >= len_eff) ? '0
                                                       : bus.jmp_target;

    assign pc_x  = {{(SW-AW){1'b0}}, pc_q};
    assign off_x = {{(SW-DW){bus.jro_off[DW-1]}}, bus.jro_off};
    assign len_x = {{(SW-AW-1){1'b0}}, len_eff};
    assign sum_s = pc_x + off_x;

    always_comb begin
        jro_pc = '0;
        if (sum_s[SW-1]) begin
            jro_pc = '0;
        end else if (sum_s >= len_x) begin
            jro_pc = len_m1;
        end else begin
            jro_pc = sum_s[AW-1:0];
        end
    end

    always_comb begin
        take    = 1'b0;
        next_pc = seq_pc;
        if (bus.jmp_kind == K_JRO) begin
            take    = 1'b1;
            next_pc = jro_pc;
        end else if (cond_taken) begin
            take    = 1'b1;
            next_pc = abs_pc;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        jt_d    = 1'b0;
        wrap_d  = 1'b0;
        unique case (state_q)
            RUN: begin
                // Halt wins over stall and freezes the PC
                if (bus.hlt) begin
                    state_d = HALTED;
                end else if (!bus.stall) begin
                    pc_d   = next_pc;
                    jt_d   = take;
                    wrap_d = !take && seq_wrap;
                end
            end
            HALTED: begin
                if (bus.ackw && !bus.hlt) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= '0;
            jt_q    <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            jt_q    <= jt_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.pc_o          = pc_q;
    assign bus.fetch_valid_o = (state_q == RUN);
    assign bus.halted_o      = (state_q == HALTED);
    assign bus.jump_taken_o  = jt_q;
    assign bus.wrap_o        = wrap_q;

    // K_NONE is listed for readability of the kind encoding
    logic unused_k;
    assign unused_k = ^K_NONE;

endmodule
